// File: rtl/alu_pkg.sv
// Shared ALU types: FSM states and the compare-flag bundle used by the serial
// arithmetic units.
package alu_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef struct packed {
    logic zero;
    logic borrow;
    logic overflow;
    logic lt;
  } flags_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake plus operand and result bus of the serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = alu_pkg::DEF_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;
  logic             overflow;
  logic             lt;

  modport master (output start, a, b,
                  input  busy, done, diff, borrow_out, zero, overflow, lt);
  modport slave  (input  start, a, b,
                  output busy, done, diff, borrow_out, zero, overflow, lt);
endinterface

// File: rtl/serial_subtractor_fsub.sv
// Gate-level full subtractor built from two half subtractors, mirroring the
// full-adder cell structure.
module half_subtractor (
  input  logic x_i,
  input  logic y_i,
  output logic d_o,
  output logic bo_o
);
  assign d_o  = x_i ^ y_i;
  assign bo_o = ~x_i & y_i;
endmodule

module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  logic d1, b1, b2;

  half_subtractor u_hs0 (.x_i(a_i), .y_i(b_i),   .d_o(d1),  .bo_o(b1));
  half_subtractor u_hs1 (.x_i(d1),  .y_i(bin_i), .d_o(d_o), .bo_o(b2));

  assign bout_o = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock, with zero/borrow/overflow/lt
// flags; WIDTH shift cycles followed by a single done cycle.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sb_q;
  logic [WIDTH-2:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  logic [WIDTH-1:0]   diff_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               bf_q;
  flags_t             flags_q, flags_d;
  logic               accept, last;
  logic               d, bout, ovf;

  full_subtractor u_fs (
    .a_i(sa_q[0]), .b_i(sb_q[0]), .bin_i(bf_q), .d_o(d), .bout_o(bout)
  );

  assign last  = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH-1));
  assign res_d = {d, res_q};
  // At the last bit sa_q[0]/sb_q[0] are the operand MSBs.
  assign ovf   = (sa_q[0] ^ sb_q[0]) & (d ^ sa_q[0]);

  always_comb begin
    flags_d          = '0;
    flags_d.zero     = (res_d == '0);
    flags_d.borrow   = bout;
    flags_d.overflow = ovf;
    flags_d.lt       = d ^ ovf;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE:    if (bus.start) accept = 1'b1;
      SHIFT:   if (last) state_d = DONE;
      DONE:    if (bus.start) accept = 1'b1;
               else           state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) state_d = SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bf_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sa_q  <= bus.a;
        sb_q  <= bus.b;
        bf_q  <= 1'b0;
        cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
        sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
        res_q <= res_d[WIDTH-1:1];
        bf_q  <= bout;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last) begin
          diff_q  <= res_d;
          flags_q <= flags_d;
        end
      end
    end
  end

  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = flags_q.borrow;
  assign bus.zero       = flags_q.zero;
  assign bus.overflow   = flags_q.overflow;
  assign bus.lt         = flags_q.lt;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for the 8-bit serial subtractor: arithmetic/flag vectors,
// handshake corner cases and asynchronous reset mid-operation.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Called at a negedge; returns at the negedge of the first SHIFT cycle.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.a = av; bus.b = bv; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts cycles (starting at 1) until done, with a bound.
  task automatic wait_done(input int first, output int cyc, output int nbusy);
    cyc = first; nbusy = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.borrow_out, bus.zero, bus.overflow, bus.lt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b diff=%h b=%b z=%b o=%b lt=%b want all 0",
               bus.busy, bus.done, bus.diff, bus.borrow_out, bus.zero, bus.overflow, bus.lt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [W-1:0] va [5] = '{8'h05, 8'h03, 8'h80, 8'h5A, 8'h7F};
    logic [W-1:0] vb [5] = '{8'h03, 8'h05, 8'h01, 8'h5A, 8'hFF};
    logic [W-1:0] ed [5] = '{8'h02, 8'hFE, 8'h7F, 8'h00, 8'h80};
    // {borrow, zero, overflow, lt}
    logic [3:0]   ef [5] = '{4'b0000, 4'b1001, 4'b0011, 4'b0100, 4'b1010};
    int cyc, nb;
    for (int i = 0; i < 5; i++) begin
      issue(va[i], vb[i]);
      wait_done(1, cyc, nb);
      checks++;
      if (cyc !== 9 || nb !== 8) begin
        errors++;
        $display("FAIL arith_latency[%0d] got done_cycle=%0d busy_cycles=%0d want 9/8", i, cyc, nb);
      end
      checks++;
      if (bus.diff !== ed[i]) begin
        errors++;
        $display("FAIL arith_diff[%0d] got %h want %h", i, bus.diff, ed[i]);
      end
      checks++;
      if ({bus.borrow_out, bus.zero, bus.overflow, bus.lt} !== ef[i]) begin
        errors++;
        $display("FAIL arith_flags[%0d] got bzol=%b%b%b%b want %b", i,
                 bus.borrow_out, bus.zero, bus.overflow, bus.lt, ef[i]);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse[%0d] got done=%b busy=%b after done cycle want 0/0", i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nb;
    issue(8'h10, 8'h01);
    @(negedge clk);                       // cycle 2
    checks++;
    if (bus.diff !== 8'h80) begin
      errors++;
      $display("FAIL hold_during_shift got diff=%h want 80", bus.diff);
    end
    @(negedge clk);                       // cycle 3: start while busy
    bus.start = 1'b1; bus.a = 8'hFF;
    @(negedge clk);                       // cycle 4
    bus.start = 1'b0; bus.a = 8'h00;
    wait_done(4, cyc, nb);
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL ignore_start_latency got done_cycle=%0d want 9", cyc);
    end
    checks++;
    if (bus.diff !== 8'h0F || bus.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_result got diff=%h borrow=%b want 0f/0", bus.diff, bus.borrow_out);
    end
    // start held during the done cycle
    issue(8'h02, 8'h03);
    checks++;
    if (bus.busy !== 1'b1 || bus.diff !== 8'h0F) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b diff=%h want 1/0f", bus.busy, bus.diff);
    end
    wait_done(1, cyc, nb);
    checks++;
    if (cyc !== 9 || nb !== 8) begin
      errors++;
      $display("FAIL b2b_latency got done_cycle=%0d busy_cycles=%0d want 9/8", cyc, nb);
    end
    checks++;
    if (bus.diff !== 8'hFF || bus.borrow_out !== 1'b1 || bus.lt !== 1'b1 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result got diff=%h borrow=%b lt=%b zero=%b want ff/1/1/0",
               bus.diff, bus.borrow_out, bus.lt, bus.zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, nb;
    int seen_done;
    issue(8'hC3, 8'h21);
    repeat (3) @(negedge clk);            // cycle 4
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.borrow_out, bus.zero, bus.overflow, bus.lt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b diff=%h b=%b z=%b o=%b lt=%b want all 0",
               bus.busy, bus.done, bus.diff, bus.borrow_out, bus.zero, bus.overflow, bus.lt);
    end
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d stray busy/done cycles want 0", seen_done);
    end
    issue(8'h21, 8'hC3);
    wait_done(1, cyc, nb);
    checks++;
    if (cyc !== 9 || nb !== 8) begin
      errors++;
      $display("FAIL post_reset_latency got done_cycle=%0d busy_cycles=%0d want 9/8", cyc, nb);
    end
    checks++;
    if (bus.diff !== 8'h5E || {bus.borrow_out, bus.zero, bus.overflow, bus.lt} !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset_result got diff=%h bzol=%b%b%b%b want 5e/1000",
               bus.diff, bus.borrow_out, bus.zero, bus.overflow, bus.lt);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
